// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART receiver.
// The StParity state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } rx_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic int unsigned calc_level_w(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on pop_data while not empty.
module rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LEVEL_W   = calc_level_w(FIFO_DEPTH),
  localparam int unsigned ADDR_W    = clog2(FIFO_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [LEVEL_W-1:0]   level
);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_q, rd_q;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 push_ok, pop_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LEVEL_W'(FIFO_DEPTH));
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign level    = level_q;
  assign pop_data = empty ? '0 : mem_q[rd_q];

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with baud divider and output FIFO in one clock domain.
// Define UART_RX_PARITY_EN to add a parity bit checked against PARITY_ODD.
module uart_rx_buffered
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0,
  localparam int unsigned LEVEL_W   = calc_level_w(FIFO_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic [LEVEL_W-1:0]   fifo_level,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overflow
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DIV_W = clog2(DIV + 1);
  localparam int unsigned OS_W  = clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = clog2(DATA_BITS);

  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  logic [1:0]           sync_q, fill_q;
  logic                 high_q, rx_s, fall;
  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 half_done, full_done, last_bit, par_bad;
  logic                 push, pop, full, empty;

  assign tick = enable && (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (!enable || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // fill_q marks when sync_q carries real line samples, so the reset preset of 1
  // never counts as a high level and a line held low out of reset is not a start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      fill_q <= 2'b00;
      high_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      fill_q <= {fill_q[0], 1'b1};
      high_q <= fill_q[1] & rx_s;
    end
  end

  assign rx_s      = sync_q[1];
  assign fall      = high_q & ~rx_s;
  assign half_done = tick && (os_q == OS_W'(OVERSAMPLE / 2 - 1));
  assign full_done = tick && (os_q == OS_W'(OVERSAMPLE - 1));
  assign last_bit  = (bit_q == BIT_W'(DATA_BITS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (fall) state_d = StStart;
        StStart:  if (half_done) state_d = rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
        StData:   if (full_done && last_bit) state_d = StParity;
        StParity: if (full_done) state_d = StStop;
`else
        StData:   if (full_done && last_bit) state_d = StStop;
`endif
        StStop:   if (full_done) state_d = rx_s ? StIdle : StBreak;
        StBreak:  if (rx_s) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (state_q == StStop && full_done) begin
      frame_err  = !rx_s;
      parity_err = par_bad;
      push       = rx_s && !par_bad;
    end
  end

  // Tick counter restarts on every state change and after each full bit period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_d != state_q || full_done) begin
        os_q <= '0;
      end else if (tick) begin
        os_q <= os_q + 1'b1;
      end
      if (state_q != StData) begin
        bit_q <= '0;
      end else if (full_done) begin
        bit_q <= bit_q + 1'b1;
      end
      if (state_q == StData && full_done) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (state_q == StParity && full_done) begin
      par_q <= rx_s;
    end
  end

  assign par_bad = ((^{shift_q, par_q}) != PARITY_ODD[0]);
`else
  assign par_bad = 1'b0;
`endif

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !empty;
  assign overflow = push && full && !pop;

  rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: 160 clocks per bit, 16-entry FIFO.
module tb_uart_rx_buffered;

  localparam int BIT_CLKS = 160;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_level;
  logic       frame_err, parity_err, overflow;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0, pop_cnt = 0, frame_cnt = 0, par_cnt = 0, ovf_cnt = 0, ovf_cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx_buffered #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16),
    .PARITY_ODD (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: event counters plus scoreboard check of every popped byte.
  initial forever begin
    logic [7:0] exp_b;
    @(negedge clock);
    if (rx_valid) valid_cnt++;
    if (frame_err) frame_cnt++;
    if (parity_err) par_cnt++;
    if (overflow) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
    if (rx_valid && rx_ready) begin
      pop_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %02h, nothing expected", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          n_fail++;
          $display("FAIL pop_data: got %02h want %02h", rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic align10();
    for (int i = 0; i < 20 && (cyc % 10) != 0; i++) idle(1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      idle(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    idle(BIT_CLKS);
`else
    if (par === 1'bx) idle(0);
`endif
    rx = stop;
    idle(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] data);
    send_frame(data, ^data, 1'b1);
    rx = 1'b1;
    idle(20);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 64 && fifo_level != 0; i++) idle(1);
    idle(2);
    rx_ready = 1'b0;
    n_tests++;
    if (fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_level: got %0d want 0", fifo_level);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d bytes never popped, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_tests++;
    if ({rx_valid, rx_data, fifo_level, frame_err, parity_err, overflow} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%02h l=%0d fe=%b pe=%b ov=%b want all 0",
               rx_valid, rx_data, fifo_level, frame_err, parity_err, overflow);
    end
    reset = 1'b1;
    idle(10);
    n_tests++;
    if (rx_valid !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset: got v=%b l=%0d want 0 0", rx_valid, fifo_level);
    end
  endtask

  task automatic test_single();
    int v0, p0, e0;
    v0 = valid_cnt; p0 = pop_cnt; e0 = frame_cnt + par_cnt + ovf_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    rx_ready = 1'b0;
    n_tests++;
    if ((valid_cnt - v0) !== 1) begin
      n_fail++;
      $display("FAIL single_valid_cycles: got %0d want 1", valid_cnt - v0);
    end
    n_tests++;
    if ((pop_cnt - p0) !== 1) begin
      n_fail++;
      $display("FAIL single_pops: got %0d want 1", pop_cnt - p0);
    end
    n_tests++;
    if ((frame_cnt + par_cnt + ovf_cnt - e0) !== 0) begin
      n_fail++;
      $display("FAIL single_errors: got %0d want 0", frame_cnt + par_cnt + ovf_cnt - e0);
    end
  endtask

  task automatic test_overflow();
    int o0;
    o0 = ovf_cnt;
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
    end
    n_tests++;
    if (fifo_level !== 5'd16 || (ovf_cnt - o0) !== 0) begin
      n_fail++;
      $display("FAIL fill_16: got level=%0d ovf=%0d want 16 0", fifo_level, ovf_cnt - o0);
    end
    send_byte(8'h10);
    n_tests++;
    if (fifo_level !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow_level: got %0d want 16", fifo_level);
    end
    n_tests++;
    if ((ovf_cnt - o0) !== 1) begin
      n_fail++;
      $display("FAIL overflow_pulses: got %0d want 1", ovf_cnt - o0);
    end
  endtask

  // Calibrate the push cycle with a dropped byte, then pop in exactly that cycle.
  task automatic test_full_pop();
    int o0, p0, start, offset;
    o0 = ovf_cnt;
    align10();
    start = cyc;
    send_byte(8'hEE);
    n_tests++;
    if ((ovf_cnt - o0) !== 1) begin
      n_fail++;
      $display("FAIL calib_overflow: got %0d want 1", ovf_cnt - o0);
    end
    offset = ovf_cyc - start;
    align10();
    start = cyc;
    o0 = ovf_cnt;
    p0 = pop_cnt;
    exp_q.push_back(8'h77);
    fork
      send_byte(8'h77);
      begin
        for (int i = 0; i < 4000 && cyc != start + offset; i++) idle(1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    n_tests++;
    if (fifo_level !== 5'd16) begin
      n_fail++;
      $display("FAIL full_pop_level: got %0d want 16", fifo_level);
    end
    n_tests++;
    if ((ovf_cnt - o0) !== 0 || (pop_cnt - p0) !== 1) begin
      n_fail++;
      $display("FAIL full_pop_events: got ovf=%0d pops=%0d want 0 1",
               ovf_cnt - o0, pop_cnt - p0);
    end
    drain();
  endtask

  task automatic test_frame_err();
    int f0, p0;
    f0 = frame_cnt; p0 = pop_cnt;
    rx_ready = 1'b1;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(300);
    rx = 1'b1;
    idle(200);
    n_tests++;
    if ((frame_cnt - f0) !== 1) begin
      n_fail++;
      $display("FAIL frame_err_pulses: got %0d want 1", frame_cnt - f0);
    end
    n_tests++;
    if (fifo_level !== 5'd0 || (pop_cnt - p0) !== 0) begin
      n_fail++;
      $display("FAIL frame_err_dropped: got level=%0d pops=%0d want 0 0",
               fifo_level, pop_cnt - p0);
    end
    exp_q.push_back(8'h55);
    send_byte(8'h55);
    rx_ready = 1'b0;
    n_tests++;
    if ((pop_cnt - p0) !== 1 || (frame_cnt - f0) !== 1) begin
      n_fail++;
      $display("FAIL after_break: got pops=%0d fe=%0d want 1 1", pop_cnt - p0, frame_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int v0, e0, p0;
    v0 = valid_cnt; e0 = frame_cnt + par_cnt + ovf_cnt;
    rx_ready = 1'b1;
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(400);
    n_tests++;
    if ((valid_cnt - v0) !== 0 || (frame_cnt + par_cnt + ovf_cnt - e0) !== 0) begin
      n_fail++;
      $display("FAIL glitch: got valid=%0d errs=%0d want 0 0",
               valid_cnt - v0, frame_cnt + par_cnt + ovf_cnt - e0);
    end
    p0 = pop_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    rx_ready = 1'b0;
    n_tests++;
    if ((pop_cnt - p0) !== 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_glitch: got pops=%0d pending=%0d want 1 0", pop_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_parity();
    int q0, p0;
    q0 = par_cnt; p0 = pop_cnt;
`ifdef UART_RX_PARITY_EN
    rx_ready = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    idle(20);
    n_tests++;
    if ((pop_cnt - p0) !== 1 || (par_cnt - q0) !== 0) begin
      n_fail++;
      $display("FAIL parity_good: got pops=%0d pe=%0d want 1 0", pop_cnt - p0, par_cnt - q0);
    end
    send_frame(8'h07, 1'b0, 1'b1);
    rx = 1'b1;
    idle(20);
    rx_ready = 1'b0;
    n_tests++;
    if ((pop_cnt - p0) !== 1 || (par_cnt - q0) !== 1 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL parity_bad: got pops=%0d pe=%0d level=%0d want 1 1 0",
               pop_cnt - p0, par_cnt - q0, fifo_level);
    end
`else
    n_tests++;
    if (par_cnt !== 0 || (pop_cnt - p0) !== 0) begin
      n_fail++;
      $display("FAIL parity_disabled: got pe=%0d want 0", par_cnt);
    end
`endif
  endtask

  task automatic test_enable();
    int v0, e0, p0;
    rx_ready = 1'b0;
    exp_q.push_back(8'h3E);
    send_byte(8'h3E);
    p0 = pop_cnt;
    enable = 1'b0;
    rx_ready = 1'b1;
    idle(5);
    rx_ready = 1'b0;
    enable = 1'b1;
    n_tests++;
    if ((pop_cnt - p0) !== 1 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL pop_while_disabled: got pops=%0d level=%0d want 1 0",
               pop_cnt - p0, fifo_level);
    end
    v0 = valid_cnt; e0 = frame_cnt + par_cnt + ovf_cnt;
    rx = 1'b0;
    idle(400);
    enable = 1'b0;
    rx = 1'b1;
    idle(50);
    enable = 1'b1;
    idle(2000);
    n_tests++;
    if ((valid_cnt - v0) !== 0 || (frame_cnt + par_cnt + ovf_cnt - e0) !== 0) begin
      n_fail++;
      $display("FAIL abandon_frame: got valid=%0d errs=%0d want 0 0",
               valid_cnt - v0, frame_cnt + par_cnt + ovf_cnt - e0);
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    rx_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n_tests++;
    if (fifo_level !== 5'd3) begin
      n_fail++;
      $display("FAIL queued_3: got %0d want 3", fifo_level);
    end
    rx = 1'b0;
    idle(300);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rx_valid, rx_data, fifo_level, frame_err, parity_err, overflow} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got v=%b d=%02h l=%0d fe=%b pe=%b ov=%b want all 0",
               rx_valid, rx_data, fifo_level, frame_err, parity_err, overflow);
    end
    rx = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(10);
    p0 = pop_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_byte(8'h81);
    rx_ready = 1'b0;
    n_tests++;
    if ((pop_cnt - p0) !== 1 || exp_q.size() != 0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL after_reset_rx: got pops=%0d pending=%0d level=%0d want 1 0 0",
               pop_cnt - p0, exp_q.size(), fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_frame_err();
    test_glitch();
    test_parity();
    test_enable();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
